// File: rtl/sha3_state_serializer.sv
// +----------------------------------------------------------------------------+
// | sha3_state_serializer: double-buffered 25-lane state capture, lane stream. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sha3_state_serializer #(
  parameter int OUT_LANES = 25
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             good,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  output logic [63:0]      odata,
  output logic [4:0]       olane,
  output logic             ovalid,
  input  logic             oready,
  output logic             olast,
  output logic [1:0]       pending,
  output logic             overflow
);

  localparam int         NUM_LANES = 25;
  localparam logic [4:0] LAST_LANE = 5'(OUT_LANES - 1);

  if (OUT_LANES < 1 || OUT_LANES > NUM_LANES) begin : g_bad_out_lanes
    $error("sha3_state_serializer: OUT_LANES must be within 1..25");
  end

  logic [63:0] r_slot [2][NUM_LANES];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [4:0]  r_lane;
  logic [1:0]  r_pending;
  logic        r_overflow;

  logic [63:0] w_lanes [NUM_LANES];
  logic        w_valid;
  logic        w_last;
  logic        w_xfer;
  logic        w_done;
  logic        w_capture;
  logic        w_drop;

  always_comb begin
    for (int c = 0; c < 5; c++) begin
      w_lanes[c]      = isa[c];
      w_lanes[5 + c]  = isb[c];
      w_lanes[10 + c] = isc[c];
      w_lanes[15 + c] = isd[c];
      w_lanes[20 + c] = ise[c];
    end
  end

  // A completing transfer frees the read slot this edge, so a full buffer can
  // still accept a new state into it while the old lane is on the output.
  assign w_valid   = (r_pending != 2'd0);
  assign w_last    = w_valid && (r_lane == LAST_LANE);
  assign w_xfer    = w_valid && oready;
  assign w_done    = w_xfer && w_last;
  assign w_capture = good && ((r_pending != 2'd2) || w_done);
  assign w_drop    = good && !w_capture;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          r_slot[s][k] <= '0;
        end
      end
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_lane     <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_capture) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          r_slot[r_wr_ptr][k] <= w_lanes[k];
        end
        r_wr_ptr <= ~r_wr_ptr;
      end

      if (w_done) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_lane   <= '0;
      end else if (w_xfer) begin
        r_lane <= r_lane + 5'd1;
      end

      case ({w_capture, w_done})
        2'b10:   r_pending <= r_pending + 2'd1;
        2'b01:   r_pending <= r_pending - 2'd1;
        default: r_pending <= r_pending;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign odata    = r_slot[r_rd_ptr][r_lane];
  assign olane    = r_lane;
  assign ovalid   = w_valid;
  assign olast    = w_last;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sha3_state_serializer.sv
// +----------------------------------------------------------------------------+
// | tb_sha3_state_serializer: directed vectors for the state lane serializer.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sha3_state_serializer;

  logic             clk = 1'b0;
  logic             rstn;
  logic             good;
  logic             oready;
  logic [4:0][63:0] isa, isb, isc, isd, ise;

  logic [63:0] odata, odata4, odata1;
  logic [4:0]  olane, olane4, olane1;
  logic        ovalid, ovalid4, ovalid1;
  logic        olast, olast4, olast1;
  logic [1:0]  pending, pending4, pending1;
  logic        overflow, overflow4, overflow1;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sha3_state_serializer #(.OUT_LANES(25)) dut (
    .clk(clk), .rstn(rstn), .good(good),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .odata(odata), .olane(olane), .ovalid(ovalid), .oready(oready),
    .olast(olast), .pending(pending), .overflow(overflow)
  );

  sha3_state_serializer #(.OUT_LANES(4)) dut4 (
    .clk(clk), .rstn(rstn), .good(good),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .odata(odata4), .olane(olane4), .ovalid(ovalid4), .oready(oready),
    .olast(olast4), .pending(pending4), .overflow(overflow4)
  );

  sha3_state_serializer #(.OUT_LANES(1)) dut1 (
    .clk(clk), .rstn(rstn), .good(good),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .odata(odata1), .olane(olane1), .ovalid(ovalid1), .oready(oready),
    .olast(olast1), .pending(pending1), .overflow(overflow1)
  );

  function automatic logic [63:0] lv(input int s, input int k);
    return 64'h1000 + 64'(s) * 64'h100 + 64'(k);
  endfunction

  task automatic set_state(input int s);
    for (int c = 0; c < 5; c++) begin
      isa[c] = lv(s, c);
      isb[c] = lv(s, 5 + c);
      isc[c] = lv(s, 10 + c);
      isd[c] = lv(s, 15 + c);
      ise[c] = lv(s, 20 + c);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    good   = 1'b0;
    oready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        good;
    int          st;
    logic        rdy;
    logic        vld;
    int          lane;
    logic        last;
    int          pend;
    logic        ovf;
    logic        dchk;
    logic [63:0] data;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int cyc;
    int e;
    bit fin;
    bit prev_hold;
    logic [63:0] prev_data;
    logic [4:0]  prev_lane;

    // OUT_LANES=4: overflow, full-buffer capture on completion, hold, olast
    tbl[0]  = '{1, 1, 0, 1, 0, 0, 1, 0, 1, lv(1, 0)};
    tbl[1]  = '{1, 2, 0, 1, 0, 0, 2, 0, 1, lv(1, 0)};
    tbl[2]  = '{1, 3, 0, 1, 0, 0, 2, 1, 1, lv(1, 0)};
    tbl[3]  = '{0, 0, 1, 1, 1, 0, 2, 1, 1, lv(1, 1)};
    tbl[4]  = '{0, 0, 1, 1, 2, 0, 2, 1, 1, lv(1, 2)};
    tbl[5]  = '{0, 0, 0, 1, 2, 0, 2, 1, 1, lv(1, 2)};
    tbl[6]  = '{0, 0, 1, 1, 3, 1, 2, 1, 1, lv(1, 3)};
    tbl[7]  = '{1, 4, 1, 1, 0, 0, 2, 1, 1, lv(2, 0)};
    tbl[8]  = '{0, 0, 1, 1, 1, 0, 2, 1, 1, lv(2, 1)};
    tbl[9]  = '{0, 0, 1, 1, 2, 0, 2, 1, 1, lv(2, 2)};
    tbl[10] = '{0, 0, 1, 1, 3, 1, 2, 1, 1, lv(2, 3)};
    tbl[11] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, lv(4, 0)};
    tbl[12] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, lv(4, 1)};
    tbl[13] = '{0, 0, 1, 1, 2, 0, 1, 1, 1, lv(4, 2)};
    tbl[14] = '{0, 0, 1, 1, 3, 1, 1, 1, 1, lv(4, 3)};
    tbl[15] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 64'h0};

    set_state(0);
    do_reset();

    chk("rst_ovalid", 64'(ovalid), 64'h0);
    chk("rst_olane", 64'(olane), 64'h0);
    chk("rst_olast", 64'(olast), 64'h0);
    chk("rst_pending", 64'(pending), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_odata", odata, 64'h0);
    chk("rst_olast_n1", 64'(olast1), 64'h0);

    // single state, full stream
    oready = 1'b1;
    set_state(0);
    good = 1'b1;
    tick();
    good = 1'b0;
    chk("latency_ovalid", 64'(ovalid), 64'h1);
    for (int k = 0; k < 25; k++) begin
      chk($sformatf("single_lane%0d", k), 64'(olane), 64'(k));
      chk($sformatf("single_data%0d", k), odata, lv(0, k));
      chk($sformatf("single_last%0d", k), 64'(olast), 64'(k == 24));
      tick();
    end
    chk("single_pending_end", 64'(pending), 64'h0);
    chk("single_ovalid_end", 64'(ovalid), 64'h0);

    // back-to-back states, no bubble
    set_state(1);
    good = 1'b1;
    tick();
    good = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("b2b_valid%0d", i), 64'(ovalid), 64'h1);
      chk($sformatf("b2b_lane%0d", i), 64'(olane), 64'(i % 25));
      chk($sformatf("b2b_data%0d", i), odata, lv(1 + i / 25, i % 25));
      if (i == 5) begin
        set_state(2);
        good = 1'b1;
      end
      tick();
      good = 1'b0;
    end
    chk("b2b_pending_end", 64'(pending), 64'h0);

    // irregular oready with a scoreboard
    do_reset();
    cyc = 0;
    fin = 1'b0;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_lane = '0;
    while (!fin) begin
      if (prev_hold) begin
        chk("hold_data", odata, prev_data);
        chk("hold_lane", 64'(olane), 64'(prev_lane));
      end
      good = (cyc == 0 || cyc == 30 || cyc == 60 || cyc == 90);
      if (good) begin
        set_state(10 + cyc / 30);
        for (int k = 0; k < 25; k++) q.push_back((10 + cyc / 30) * 32 + k);
      end
      oready = ((cyc * 7) % 5 != 0);
      if (ovalid && oready) begin
        if (q.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL sb_extra: got lane %0d expected no transfer", olane);
        end else begin
          e = q.pop_front();
          chk("sb_data", odata, lv(e / 32, e % 32));
          chk("sb_lane", 64'(olane), 64'(e % 32));
        end
      end
      prev_hold = ovalid && !oready;
      prev_data = odata;
      prev_lane = olane;
      tick();
      good = 1'b0;
      cyc++;
      if (cyc >= 100 && q.size() == 0) fin = 1'b1;
      if (cyc >= 400) begin
        ncmp++;
        nfail++;
        $display("FAIL sb_timeout: got %0d lanes left expected 0", q.size());
        fin = 1'b1;
      end
    end
    chk("sb_pending_end", 64'(pending), 64'h0);
    chk("sb_overflow", 64'(overflow), 64'h0);

    // table vectors against OUT_LANES=4
    do_reset();
    for (int i = 0; i < 16; i++) begin
      good = tbl[i].good;
      if (tbl[i].good) set_state(tbl[i].st);
      oready = tbl[i].rdy;
      tick();
      good = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 64'(ovalid4), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_lane", i), 64'(olane4), 64'(tbl[i].lane));
      chk($sformatf("tbl%0d_last", i), 64'(olast4), 64'(tbl[i].last));
      chk($sformatf("tbl%0d_pending", i), 64'(pending4), 64'(tbl[i].pend));
      chk($sformatf("tbl%0d_overflow", i), 64'(overflow4), 64'(tbl[i].ovf));
      if (tbl[i].dchk) chk($sformatf("tbl%0d_data", i), odata4, tbl[i].data);
    end

    // reset in the middle of emission
    do_reset();
    for (int s = 1; s <= 3; s++) begin
      set_state(s);
      good = 1'b1;
      tick();
    end
    good = 1'b0;
    chk("mid_overflow_set", 64'(overflow), 64'h1);
    chk("mid_pending_full", 64'(pending), 64'h2);
    oready = 1'b1;
    for (int i = 0; i < 40 && olane != 5'd10; i++) tick();
    chk("mid_reach_lane10", 64'(olane), 64'd10);
    rstn = 1'b0;
    set_state(5);
    good = 1'b1;
    tick();
    rstn = 1'b1;
    good = 1'b0;
    chk("mid_ovalid", 64'(ovalid), 64'h0);
    chk("mid_pending", 64'(pending), 64'h0);
    chk("mid_overflow", 64'(overflow), 64'h0);
    chk("mid_olane", 64'(olane), 64'h0);
    chk("mid_odata", odata, 64'h0);
    tick();
    chk("mid_good_ignored", 64'(pending), 64'h0);
    set_state(6);
    good = 1'b1;
    tick();
    good = 1'b0;
    chk("mid_new_valid", 64'(ovalid), 64'h1);
    chk("mid_new_lane", 64'(olane), 64'h0);
    chk("mid_new_data", odata, lv(6, 0));

    // OUT_LANES=1: olast on every valid cycle
    do_reset();
    oready = 1'b1;
    set_state(7);
    good = 1'b1;
    tick();
    set_state(8);
    chk("n1_last_a", 64'(olast1), 64'h1);
    chk("n1_lane_a", 64'(olane1), 64'h0);
    chk("n1_data_a", odata1, lv(7, 0));
    tick();
    good = 1'b0;
    chk("n1_last_b", 64'(olast1), 64'h1);
    chk("n1_data_b", odata1, lv(8, 0));
    chk("n1_pending_b", 64'(pending1), 64'h1);
    tick();
    chk("n1_pending_end", 64'(pending1), 64'h0);
    chk("n1_last_end", 64'(olast1), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
